// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for IF-stage next-PC selection, one resolved update per cycle from EX.
module branch_target_buffer #(
    parameter int         WIDTH    = 32,
    parameter int         ENTRIES  = 8,
    parameter logic [1:0] CNT_INIT = 2'd2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             lookup_pc,
    output logic                         predict_taken,
    output logic [WIDTH-1:0]             predict_target,
    input  logic                         upd_valid,
    input  logic [WIDTH-1:0]             upd_pc,
    input  logic [WIDTH-1:0]             upd_target,
    input  logic                         upd_taken,
    output logic [$clog2(ENTRIES):0]     occupancy
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - 2;
    localparam int OCCW = IDXW + 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [WIDTH-1:0]   target_q [ENTRIES];
    logic [WIDTH-1:0]   target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [IDXW-1:0]    ptr_q, ptr_d;
    logic [OCCW-1:0]    occ_q, occ_d;

    logic               lk_hit, up_hit, free_any;
    logic [IDXW-1:0]    lk_idx, up_idx, free_idx, victim;

    // Byte offset bits never take part in tag compare.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_pc[WIDTH-1:2])) begin
                lk_hit = 1'b1;
                lk_idx = IDXW'(i);
            end
            if (valid_q[i] && (tag_q[i] == upd_pc[WIDTH-1:2])) begin
                up_hit = 1'b1;
                up_idx = IDXW'(i);
            end
        end
    end

    // Descending scan so the lowest free index is the one that sticks.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDXW'(i);
            end
        end
    end

    assign predict_taken  = lk_hit && cnt_q[lk_idx][1];
    assign predict_target = lk_hit ? target_q[lk_idx] : (lookup_pc + WIDTH'(4));
    assign occupancy      = occ_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        occ_d    = occ_q;
        victim   = free_any ? free_idx : ptr_q;
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    cnt_d[up_idx]    = (cnt_q[up_idx] == 2'd3) ? 2'd3 : (cnt_q[up_idx] + 2'd1);
                    target_d[up_idx] = upd_target;
                end else begin
                    cnt_d[up_idx]    = (cnt_q[up_idx] == 2'd0) ? 2'd0 : (cnt_q[up_idx] - 2'd1);
                end
            end else if (upd_taken) begin
                // Filling a hole grows occupancy; replacing a live entry advances round-robin.
                if (free_any) begin
                    occ_d = occ_q + OCCW'(1);
                end else begin
                    ptr_d = ptr_q + IDXW'(1);
                end
                valid_d[victim]  = 1'b1;
                tag_d[victim]    = upd_pc[WIDTH-1:2];
                target_d[victim] = upd_target;
                cnt_d[victim]    = CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
            occ_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'd0;
            end
        end else if (flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
            occ_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios then random traffic,
// all checked against an array-based reference model of the BTB rules.
module tb_branch_target_buffer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_v   [N];
    logic [29:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_cnt [N];
    int          m_ptr;

    branch_target_buffer #(.WIDTH(32), .ENTRIES(N), .CNT_INIT(2'd2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_tag[i] == pc[31:2]) return i;
        return -1;
    endfunction

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_v[i]) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_cnt[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic m_edge(input logic fl, input logic uv, input logic [31:0] upc,
                          input logic [31:0] utgt, input logic utk);
        int h, v;
        if (fl) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            m_ptr = 0;
            return;
        end
        if (!uv) return;
        h = m_find(upc);
        if (h >= 0) begin
            if (utk) begin
                m_cnt[h] = (m_cnt[h] + 1 > 3) ? 3 : m_cnt[h] + 1;
                m_tgt[h] = utgt;
            end else begin
                m_cnt[h] = (m_cnt[h] - 1 < 0) ? 0 : m_cnt[h] - 1;
            end
        end else if (utk) begin
            v = -1;
            for (int i = N - 1; i >= 0; i--) if (!m_v[i]) v = i;
            if (v < 0) begin
                v = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
            m_v[v] = 1; m_tag[v] = upc[31:2]; m_tgt[v] = utgt; m_cnt[v] = 2;
        end
    endtask

    // One clock: drive inputs, check pre-edge lookup/occupancy against model, clock, advance model.
    task automatic cyc(input logic fl, input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk, input logic [31:0] lpc);
        int h;
        flush = fl; upd_valid = uv; upd_pc = upc; upd_target = utgt;
        upd_taken = utk; lookup_pc = lpc;
        #1;
        h = m_find(lpc);
        check("predict_taken", {31'd0, predict_taken}, {31'd0, (h >= 0) && (m_cnt[h] >= 2)});
        check("predict_target", predict_target, (h >= 0) ? m_tgt[h] : lpc + 32'd4);
        check("occupancy", {28'd0, occupancy}, 32'(m_occ()));
        @(posedge clk);
        m_edge(fl, uv, upc, utgt, utk);
        #1;
    endtask

    task automatic look(input logic [31:0] lpc);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, lpc);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        cyc(1'b0, 1'b1, pc, tgt, tk, pc);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lookup_pc = 32'h100; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        lookup_pc = 32'h100;
        #1;
        check("rst_taken", {31'd0, predict_taken}, 32'd0);
        check("rst_target", predict_target, 32'h104);
        check("rst_occ", {28'd0, occupancy}, 32'd0);
        look(32'h100);

        // 2: allocate, hit, offset bits ignored
        upd(32'h100, 32'h200, 1'b1);
        look(32'h100);
        look(32'h102);
        check("alloc_occ", {28'd0, occupancy}, 32'd1);

        // 3: hysteresis and saturation
        upd(32'h100, 32'h200, 1'b0);
        upd(32'h100, 32'h200, 1'b0);
        look(32'h100);
        upd(32'h100, 32'h200, 1'b0);
        lookup_pc = 32'h100; #1;
        check("cnt0_taken", {31'd0, predict_taken}, 32'd0);
        check("cnt0_still_valid", predict_target, 32'h200);
        repeat (4) upd(32'h100, 32'h240, 1'b1);
        upd(32'h100, 32'h240, 1'b0);
        lookup_pc = 32'h100; #1;
        check("cnt2_taken", {31'd1 & 31'd0, predict_taken}, 32'd1);
        check("cnt2_target", predict_target, 32'h240);

        // 4: fill then round-robin replacement
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < N; i++) upd(32'(i * 4), 32'h1000 + 32'(i), 1'b1);
        look(32'h0);
        upd(32'h40, 32'h2040, 1'b1);
        lookup_pc = 32'h0; #1;
        check("evict_0_miss", {31'd0, predict_taken}, 32'd0);
        check("occ_full", {28'd0, occupancy}, 32'd8);
        look(32'h40);
        look(32'h4);
        upd(32'h80, 32'h2080, 1'b1);
        lookup_pc = 32'h4; #1;
        check("evict_4_miss", predict_target, 32'h8);

        // 5: not-taken miss never allocates
        upd(32'h300, 32'h900, 1'b0);
        look(32'h300);

        // 6: flush drops same-cycle update; no lookup bypass
        cyc(1'b1, 1'b1, 32'h500, 32'h700, 1'b1, 32'h500);
        check("flush_occ", {28'd0, occupancy}, 32'd0);
        look(32'h500);
        look(32'h40);
        cyc(1'b0, 1'b1, 32'h600, 32'h800, 1'b1, 32'h600);
        lookup_pc = 32'h600; #1;
        check("nobypass_next_hit", predict_target, 32'h800);

        // Random traffic over a small PC pool to exercise hits, eviction and saturation
        for (int k = 0; k < 600; k++) begin
            logic [31:0] pa, pb;
            pa = {26'd0, 4'($urandom_range(0, 11)), 2'($urandom)};
            pb = {26'd0, 4'($urandom_range(0, 11)), 2'($urandom)};
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), pa,
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, pb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
